// File: rtl/peripheral_display_scanner_if.sv
// Bus-side bundle of the display scanner: CPU write port and scan enable in, display drive out.
// dbg_state exposes the scan FSM state so checkers can bind without reaching into the block.
interface peripheral_display_scanner_if #(
    parameter int NDIG = 4
);
    logic                en;
    logic                we;
    logic [4*NDIG-1:0]   wdata;
    logic [3:0]          D;
    logic [NDIG-1:0]     AN;
    logic                frame;
    logic                pend;
    logic [1:0]          dbg_state;

    modport master (
        output en, we, wdata,
        input  D, AN, frame, pend, dbg_state
    );

    modport slave (
        input  en, we, wdata,
        output D, AN, frame, pend, dbg_state
    );
endinterface

// File: rtl/peripheral_display_scanner.sv
// Time-multiplexed common-anode 7-segment scanner with a double-buffered digit word.
// New data is committed only at frame boundaries (or while idle) so a frame is never torn.
module peripheral_display_scanner #(
    parameter int NDIG      = 4,
    parameter int SLOT_CYC  = 50000,
    parameter int BLANK_CYC = 64
) (
    input  logic                          clk,
    input  logic                          reset_n,
    peripheral_display_scanner_if.slave   bus
);
    localparam int CW = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam int IW = $clog2(NDIG);
    localparam logic [CW-1:0] ON_LAST    = CW'(SLOT_CYC - BLANK_CYC - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ON    = 2'd1;
    localparam logic [1:0] BLANK = 2'd2;

    logic [1:0]          state, state_n;
    logic [IW-1:0]       idx, idx_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [4*NDIG-1:0]   shadow, active;
    logic                pend;
    logic [3:0]          d_q;
    logic [NDIG-1:0]     an_q;
    logic                frame_q;
    logic                boundary;
    logic                commit;

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        cnt_n    = cnt;
        boundary = 1'b0;
        case (state)
            IDLE: begin
                if (bus.en) begin
                    state_n = ON;
                    idx_n   = '0;
                    cnt_n   = '0;
                end
            end
            ON: begin
                if (!bus.en) begin
                    state_n = IDLE;
                    idx_n   = '0;
                    cnt_n   = '0;
                end else if (cnt == ON_LAST) begin
                    state_n = BLANK;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            BLANK: begin
                if (!bus.en) begin
                    state_n = IDLE;
                    idx_n   = '0;
                    cnt_n   = '0;
                end else if (cnt == BLANK_LAST) begin
                    state_n = ON;
                    cnt_n   = '0;
                    // Wrapping past the last digit is the only place a frame ends.
                    if (idx == IDX_LAST) begin
                        idx_n    = '0;
                        boundary = 1'b1;
                    end else begin
                        idx_n = idx + IW'(1);
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
                cnt_n   = '0;
            end
        endcase
    end

    assign commit = boundary || ((state == IDLE) && pend);

    // Write port: we is a single-cycle strobe with no back-pressure; every strobe is accepted
    // into shadow, the last one before a commit wins, and a commit in the same cycle takes the old shadow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            idx     <= '0;
            cnt     <= '0;
            shadow  <= {NDIG{4'hF}};
            active  <= {NDIG{4'hF}};
            pend    <= 1'b0;
            d_q     <= 4'hF;
            an_q    <= '1;
            frame_q <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            cnt     <= cnt_n;
            frame_q <= boundary;
            if (commit) begin
                active <= shadow;
            end
            if (bus.we) begin
                shadow <= bus.wdata;
                pend   <= 1'b1;
            end else if (commit) begin
                pend <= 1'b0;
            end
            // Drive pins are a one-cycle registered view of the current state.
            if (state == ON) begin
                an_q <= ~(NDIG'(1) << idx);
                d_q  <= active[4*idx +: 4];
            end else begin
                an_q <= '1;
                d_q  <= 4'hF;
            end
        end
    end

    assign bus.D         = d_q;
    assign bus.AN        = an_q;
    assign bus.frame     = frame_q;
    assign bus.pend      = pend;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_peripheral_display_scanner.sv
// Self-checking bench for peripheral_display_scanner with NDIG=4, SLOT_CYC=8, BLANK_CYC=2.
// Expected digit frames are queued when data is written and popped as digits appear on the pins.
module tb_peripheral_display_scanner;
    localparam int NDIG      = 4;
    localparam int SLOT_CYC  = 8;
    localparam int BLANK_CYC = 2;
    localparam int ON_LEN    = SLOT_CYC - BLANK_CYC;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    peripheral_display_scanner_if #(.NDIG(NDIG)) bus ();

    peripheral_display_scanner #(
        .NDIG(NDIG), .SLOT_CYC(SLOT_CYC), .BLANK_CYC(BLANK_CYC)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave)
    );

    int chk_cnt = 0;
    int pass_cnt = 0;
    logic [7:0] exp_q[$];

    // ---------------- driver / observer tasks ----------------
    task automatic push_frame(input logic [15:0] v);
        logic [3:0] an_e;
        for (int i = 0; i < NDIG; i++) begin
            an_e = ~(4'b0001 << i);
            exp_q.push_back({an_e, v[4*i +: 4]});
        end
    endtask

    task automatic do_write(input logic [15:0] v);
        bus.we    = 1'b1;
        bus.wdata = v;
        @(negedge clk);
        bus.we    = 1'b0;
    endtask

    task automatic wait_an(input logic [3:0] v, output bit ok);
        int n = 0;
        while (bus.AN !== v && n < 100) begin @(negedge clk); n++; end
        ok = (n < 100);
    endtask

    task automatic wait_frame(output bit ok);
        int n = 0;
        while (bus.frame !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        ok = (n < 100);
    endtask

    // Observes one lit digit: anode pattern, code, lit length and whether D held steady.
    task automatic capture_digit(output logic [3:0] an, output logic [3:0] d,
                                 output int len, output bit stable, output bit ok);
        int n = 0;
        an = 4'hF; d = 4'hF; len = 0; stable = 1'b1;
        while (bus.AN === 4'hF && n < 100) begin @(negedge clk); n++; end
        ok = (n < 100);
        if (ok) begin
            an = bus.AN;
            d  = bus.D;
            while (bus.AN === an && len < 100) begin
                if (bus.D !== d) stable = 1'b0;
                len++;
                @(negedge clk);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0; bus.en = 1'b0; bus.we = 1'b0; bus.wdata = '0;
        repeat (3) @(negedge clk);
        chk_cnt++; if (bus.AN !== 4'hF) $display("FAIL reset_an: got %b want 1111", bus.AN); else pass_cnt++;
        chk_cnt++; if (bus.D !== 4'hF) $display("FAIL reset_d: got %h want f", bus.D); else pass_cnt++;
        chk_cnt++; if (bus.frame !== 1'b0) $display("FAIL reset_frame: got %b want 0", bus.frame); else pass_cnt++;
        chk_cnt++; if (bus.pend !== 1'b0) $display("FAIL reset_pend: got %b want 0", bus.pend); else pass_cnt++;
        chk_cnt++; if (bus.dbg_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", bus.dbg_state); else pass_cnt++;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_cnt++; if (bus.AN !== 4'hF || bus.D !== 4'hF) $display("FAIL idle_dark: got an=%b d=%h want 1111 f", bus.AN, bus.D); else pass_cnt++;
    endtask

    task automatic test_blank_scan();
        logic [3:0] an, d; int len, dark, n; bit stable, ok; logic [7:0] e;
        bus.en = 1'b1;
        push_frame(16'hFFFF);
        for (int i = 0; i < NDIG; i++) begin
            capture_digit(an, d, len, stable, ok);
            e = exp_q.pop_front();
            chk_cnt++;
            if (!ok || an !== e[7:4] || d !== e[3:0] || len != ON_LEN || !stable)
                $display("FAIL blank_scan digit%0d: got an=%b d=%h len=%0d stable=%0d want an=%b d=%h len=%0d stable=1",
                         i, an, d, len, stable, e[7:4], e[3:0], ON_LEN);
            else pass_cnt++;
            if (i < NDIG - 1) begin
                dark = 0;
                while (bus.AN === 4'hF && dark < 50) begin dark++; @(negedge clk); end
                chk_cnt++; if (dark != BLANK_CYC) $display("FAIL blank_dark%0d: got %0d want %0d", i, dark, BLANK_CYC); else pass_cnt++;
            end
        end
        wait_frame(ok);
        chk_cnt++; if (!ok) $display("FAIL frame_seen: got timeout want pulse"); else pass_cnt++;
        @(negedge clk);
        n = 1;
        while (bus.frame !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk_cnt++; if (n != NDIG * SLOT_CYC) $display("FAIL frame_period: got %0d want %0d", n, NDIG * SLOT_CYC); else pass_cnt++;
    endtask

    task automatic test_write_commit();
        logic [3:0] an, d; int len, n; bit stable, ok; logic [7:0] e;
        wait_frame(ok);
        repeat (3) @(negedge clk);
        exp_q.push_back({4'b1101, 4'hF});
        exp_q.push_back({4'b1011, 4'hF});
        exp_q.push_back({4'b0111, 4'hF});
        push_frame(16'h3210);
        do_write(16'h3210);
        chk_cnt++; if (bus.pend !== 1'b1) $display("FAIL write_pend: got %b want 1", bus.pend); else pass_cnt++;
        n = 0;
        while (bus.AN !== 4'hF && n < 50) begin @(negedge clk); n++; end
        for (int i = 0; i < 7; i++) begin
            if (i == 3) begin
                wait_frame(ok);
                chk_cnt++; if (!ok || bus.pend !== 1'b0) $display("FAIL commit_pend: got ok=%0d pend=%b want 1 0", ok, bus.pend); else pass_cnt++;
            end
            capture_digit(an, d, len, stable, ok);
            e = exp_q.pop_front();
            chk_cnt++;
            if (!ok || an !== e[7:4] || d !== e[3:0] || len != ON_LEN || !stable)
                $display("FAIL write_commit step%0d: got an=%b d=%h len=%0d want an=%b d=%h len=%0d", i, an, d, len, e[7:4], e[3:0], ON_LEN);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] an, d; int len; bit stable, ok; logic [7:0] e;
        wait_frame(ok);
        push_frame(16'h2222);
        do_write(16'h1111);
        do_write(16'h2222);
        chk_cnt++; if (bus.pend !== 1'b1) $display("FAIL b2b_pend: got %b want 1", bus.pend); else pass_cnt++;
        @(negedge clk);
        wait_frame(ok);
        chk_cnt++; if (!ok || bus.pend !== 1'b0) $display("FAIL b2b_commit: got ok=%0d pend=%b want 1 0", ok, bus.pend); else pass_cnt++;
        for (int i = 0; i < NDIG; i++) begin
            capture_digit(an, d, len, stable, ok);
            e = exp_q.pop_front();
            chk_cnt++;
            if (!ok || an !== e[7:4] || d !== e[3:0] || !stable)
                $display("FAIL b2b digit%0d: got an=%b d=%h stable=%0d want an=%b d=%h", i, an, d, stable, e[7:4], e[3:0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_boundary_write();
        logic [3:0] an, d; int len; bit stable, ok, ok2; logic [7:0] e;
        wait_frame(ok);
        @(negedge clk);
        push_frame(16'h5555);
        push_frame(16'hAAAA);
        do_write(16'h5555);
        wait_an(4'b0111, ok);
        wait_an(4'hF, ok2);
        bus.we = 1'b1; bus.wdata = 16'hAAAA;
        @(negedge clk);
        bus.we = 1'b0;
        chk_cnt++; if (!ok || !ok2 || bus.frame !== 1'b1) $display("FAIL bnd_frame: got %b want 1", bus.frame); else pass_cnt++;
        chk_cnt++; if (bus.pend !== 1'b1) $display("FAIL bnd_pend_held: got %b want 1", bus.pend); else pass_cnt++;
        for (int i = 0; i < 2 * NDIG; i++) begin
            if (i == NDIG) begin
                wait_frame(ok);
                chk_cnt++; if (!ok || bus.pend !== 1'b0) $display("FAIL bnd_pend_clear: got ok=%0d pend=%b want 1 0", ok, bus.pend); else pass_cnt++;
            end
            capture_digit(an, d, len, stable, ok);
            e = exp_q.pop_front();
            chk_cnt++;
            if (!ok || an !== e[7:4] || d !== e[3:0] || len != ON_LEN || !stable)
                $display("FAIL bnd step%0d: got an=%b d=%h len=%0d want an=%b d=%h len=%0d", i, an, d, len, e[7:4], e[3:0], ON_LEN);
            else pass_cnt++;
        end
    endtask

    task automatic test_en_drop();
        logic [3:0] an, d; int len, frames; bit stable, ok; logic [7:0] e;
        wait_frame(ok);
        @(negedge clk);
        do_write(16'h7777);
        chk_cnt++; if (bus.pend !== 1'b1) $display("FAIL drop_pend_set: got %b want 1", bus.pend); else pass_cnt++;
        wait_an(4'b1011, ok);
        repeat (2) @(negedge clk);
        bus.en = 1'b0;
        frames = 0;
        repeat (2) begin @(negedge clk); if (bus.frame === 1'b1) frames++; end
        chk_cnt++; if (!ok || bus.AN !== 4'hF || bus.D !== 4'hF) $display("FAIL drop_dark: got an=%b d=%h want 1111 f", bus.AN, bus.D); else pass_cnt++;
        chk_cnt++; if (bus.pend !== 1'b0) $display("FAIL drop_idle_commit: got %b want 0", bus.pend); else pass_cnt++;
        chk_cnt++; if (bus.dbg_state !== 2'd0) $display("FAIL drop_state: got %0d want 0", bus.dbg_state); else pass_cnt++;
        repeat ($urandom_range(4, 10)) begin @(negedge clk); if (bus.frame === 1'b1) frames++; end
        chk_cnt++; if (frames != 0) $display("FAIL drop_no_frame: got %0d pulses want 0", frames); else pass_cnt++;
        exp_q.push_back({4'b1110, 4'h7});
        bus.en = 1'b1;
        capture_digit(an, d, len, stable, ok);
        e = exp_q.pop_front();
        chk_cnt++;
        if (!ok || an !== e[7:4] || d !== e[3:0] || len != ON_LEN || !stable)
            $display("FAIL drop_restart: got an=%b d=%h len=%0d want an=%b d=%h len=%0d", an, d, len, e[7:4], e[3:0], ON_LEN);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        logic [3:0] an, d; int len; bit stable, ok, ok2; logic [7:0] e;
        do_write(16'h9999);
        chk_cnt++; if (bus.pend !== 1'b1) $display("FAIL ar_pend_set: got %b want 1", bus.pend); else pass_cnt++;
        wait_an(4'b1101, ok);
        wait_an(4'hF, ok2);
        #2 reset_n = 1'b0;
        #1;
        chk_cnt++; if (!ok || !ok2 || bus.AN !== 4'hF || bus.D !== 4'hF) $display("FAIL ar_dark: got an=%b d=%h want 1111 f", bus.AN, bus.D); else pass_cnt++;
        chk_cnt++; if (bus.pend !== 1'b0) $display("FAIL ar_pend: got %b want 0", bus.pend); else pass_cnt++;
        chk_cnt++; if (bus.dbg_state !== 2'd0) $display("FAIL ar_state: got %0d want 0", bus.dbg_state); else pass_cnt++;
        @(negedge clk);
        reset_n = 1'b1;
        push_frame(16'hFFFF);
        for (int i = 0; i < NDIG; i++) begin
            capture_digit(an, d, len, stable, ok);
            e = exp_q.pop_front();
            chk_cnt++;
            if (!ok || an !== e[7:4] || d !== e[3:0] || len != ON_LEN || !stable)
                $display("FAIL ar_active digit%0d: got an=%b d=%h len=%0d want an=%b d=%h len=%0d", i, an, d, len, e[7:4], e[3:0], ON_LEN);
            else pass_cnt++;
        end
        chk_cnt++; if (bus.pend !== 1'b0) $display("FAIL ar_pend_after: got %b want 0", bus.pend); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_blank_scan();
        test_write_commit();
        test_back_to_back();
        test_boundary_write();
        test_en_drop();
        test_async_reset();
        chk_cnt++; if (exp_q.size() != 0) $display("FAIL queue_drained: got %0d left want 0", exp_q.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
